// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// mem_port_arbiter: shares one single-port word-addressed memory between the
// instruction-fetch port (I, read-only) and the load/store port (D).
// Round-robin arbitration, RRdy/RVld read handshake, single-cycle RWEn write,
// one-cycle Done pulse per transaction and a read watchdog.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | no transaction; arbitrate and latch the winner's request
// S_READ  | RRdy high, wait for RVld or watchdog expiry
// S_WRITE | one cycle with RWEn high
// S_RESP  | Done pulse (plus Err on timeout) to the winner, back to idle

module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          IReq,
    input  logic [AW-1:0] IAddr,
    output logic          IDone,
    output logic [DW-1:0] IData,

    input  logic          DReq,
    input  logic          DWEn,
    input  logic [AW-1:0] DAddr,
    input  logic [DW-1:0] DWData,
    output logic          DDone,
    output logic [DW-1:0] DData,

    output logic          Err,

    output logic          RRdy,
    input  logic          RVld,
    output logic [AW-1:0] RAddr,
    output logic [DW-1:0] RWData,
    output logic          RWEn,
    input  logic [DW-1:0] RData
);

    // The watchdog only needs to count 0 .. TIMEOUT-1.
    localparam int            WDW     = $clog2(TIMEOUT);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            win_q, win_d;      // 1 = D owns the current transaction
    logic            last_q, last_d;    // 1 = D was granted most recently
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [WDW-1:0]  wd_q, wd_d;
    logic            err_q, err_d;
    logic [DW-1:0]   idata_q, idata_d;
    logic [DW-1:0]   ddata_q, ddata_d;
    logic            grant_d;

    // A lone requester wins; on a tie the one not served last wins.
    assign grant_d = DReq & (~IReq | ~last_q);

    // Next-state, datapath updates and handshake outputs.
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        last_d  = last_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wd_d    = wd_q;
        err_d   = err_q;
        idata_d = idata_q;
        ddata_d = ddata_q;
        RRdy    = 1'b0;
        RWEn    = 1'b0;
        IDone   = 1'b0;
        DDone   = 1'b0;
        Err     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (IReq | DReq) begin
                    win_d  = grant_d;
                    last_d = grant_d;
                    addr_d = grant_d ? DAddr : IAddr;
                    if (grant_d) begin
                        wdata_d = DWData;
                    end
                    wd_d    = '0;
                    err_d   = 1'b0;
                    state_d = (grant_d & DWEn) ? S_WRITE : S_READ;
                end
            end
            S_READ: begin
                RRdy = 1'b1;
                if (RVld) begin
                    if (win_q) begin
                        ddata_d = RData;
                    end else begin
                        idata_d = RData;
                    end
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (wd_q == WD_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    wd_d = wd_q + WDW'(1);
                end
            end
            S_WRITE: begin
                RWEn    = 1'b1;
                state_d = S_RESP;
            end
            S_RESP: begin
                IDone   = ~win_q;
                DDone   = win_q;
                Err     = err_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            win_q   <= 1'b0;
            last_q  <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
            wd_q    <= '0;
            err_q   <= 1'b0;
            idata_q <= '0;
            ddata_q <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
            idata_q <= idata_d;
            ddata_q <= ddata_d;
        end
    end

    assign RAddr  = addr_q;
    assign RWData = wdata_q;
    assign IData  = idata_q;
    assign DData  = ddata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
// Testbench for mem_port_arbiter: directed vector table, hand-written corner
// sequences, and a randomized run against a transaction-level reference.

module tb_mem_port_arbiter;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TIMEOUT = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          IReq, DReq, DWEn;
    logic [AW-1:0] IAddr, DAddr;
    logic [DW-1:0] DWData;
    logic          IDone, DDone, Err, RRdy, RWEn;
    logic [DW-1:0] IData, DData, RWData;
    logic [AW-1:0] RAddr;
    logic          RVld;
    logic [DW-1:0] RData;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .IReq(IReq), .IAddr(IAddr), .IDone(IDone), .IData(IData),
        .DReq(DReq), .DWEn(DWEn), .DAddr(DAddr), .DWData(DWData),
        .DDone(DDone), .DData(DData), .Err(Err),
        .RRdy(RRdy), .RVld(RVld), .RAddr(RAddr), .RWData(RWData),
        .RWEn(RWEn), .RData(RData)
    );

    // Memory model: registered RVld one cycle after RRdy, cleared the cycle after.
    logic [31:0] dev_mem [16];
    logic        rvld_q  = 1'b0;
    logic [31:0] rdata_q = '0;
    logic        stall   = 1'b0;
    logic        pl_en   = 1'b0;
    logic [3:0]  pl_addr = '0;
    logic [31:0] pl_data = '0;
    logic [31:0] ref_mem [16];

    always @(posedge clk) begin
        if (pl_en) dev_mem[pl_addr] <= pl_data;
        else if (RWEn) dev_mem[RAddr[3:0]] <= RWData;
        rvld_q  <= RRdy && !rvld_q && !stall;
        rdata_q <= dev_mem[RAddr[3:0]];
    end
    assign RVld  = rvld_q;
    assign RData = rdata_q;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic preload(input logic [3:0] a, input logic [31:0] d);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        ref_mem[a] = d;
        tick();
        pl_en = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_idone"}, IDone, 0);
        chk({tag, "_ddone"}, DDone, 0);
        chk({tag, "_err"}, Err, 0);
        chk({tag, "_rrdy"}, RRdy, 0);
        chk({tag, "_rwen"}, RWEn, 0);
        chk({tag, "_raddr"}, RAddr, 0);
        chk({tag, "_rwdata"}, RWData, 0);
        chk({tag, "_idata"}, IData, 0);
        chk({tag, "_ddata"}, DData, 0);
    endtask

    // One transaction from an idle arbiter; returns with the arbiter idle again.
    task automatic do_txn(input bit is_d, input bit wen, input logic [3:0] addr,
                          input logic [31:0] wdata, output int lat, output logic err,
                          output logic [31:0] data, output logic [7:0] rrdy_m,
                          output logic [7:0] rwen_m, output bit other,
                          output logic rrdy_done);
        lat = -1; err = 0; data = 0; rrdy_m = 0; rwen_m = 0; other = 0; rrdy_done = 0;
        if (is_d) begin
            DReq = 1'b1; DWEn = wen; DAddr = {28'b0, addr}; DWData = wdata;
        end else begin
            IReq = 1'b1; IAddr = {28'b0, addr};
        end
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k < 8) begin
                rrdy_m[k] = RRdy;
                rwen_m[k] = RWEn;
            end
            if (is_d ? IDone : DDone) other = 1;
            if (is_d ? DDone : IDone) begin
                lat = k; err = Err; data = is_d ? DData : IData; rrdy_done = RRdy;
                break;
            end
        end
        IReq = 1'b0;
        DReq = 1'b0;
        tick();
    endtask

    typedef struct {
        bit          is_d;
        bit          wen;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        int          exp_lat;
    } vec_t;

    vec_t vt [6];

    int          lat;
    logic        err, rrdy_done;
    logic [31:0] data, old_idata;
    logic [7:0]  rrdy_m, rwen_m;
    bit          other;

    // Randomized-run reference state.
    bit          have_g, g_d, g_w, last_d, free, e_rrdy, e_rwen, e_done, who;
    int          g_c, rel;
    logic [31:0] g_addr, g_wdata, g_data, exp_idata, exp_ddata;

    initial begin
        vt[0] = '{0, 0, 4'd4, 32'h0,        32'h00000013, 3};
        vt[1] = '{1, 1, 4'd8, 32'hDEADBEEF, 32'h00000000, 2};
        vt[2] = '{1, 0, 4'd8, 32'h0,        32'hDEADBEEF, 3};
        vt[3] = '{0, 0, 4'd8, 32'h0,        32'hDEADBEEF, 3};
        vt[4] = '{1, 1, 4'd5, 32'hA5A50001, 32'hDEADBEEF, 2};
        vt[5] = '{1, 0, 4'd5, 32'h0,        32'hA5A50001, 3};

        rst = 1'b1; IReq = 0; DReq = 0; DWEn = 0; IAddr = 0; DAddr = 0; DWData = 0;
        tick();
        tick();
        check_all_zero("reset");
        preload(4'd4, 32'h00000013);
        rst = 1'b0;

        // Directed vector table.
        for (int i = 0; i < 6; i++) begin
            do_txn(vt[i].is_d, vt[i].wen, vt[i].addr, vt[i].wdata,
                   lat, err, data, rrdy_m, rwen_m, other, rrdy_done);
            chk($sformatf("vec%0d_lat", i), lat, vt[i].exp_lat);
            chk($sformatf("vec%0d_data", i), data, vt[i].exp_data);
            chk($sformatf("vec%0d_err", i), err, 0);
            chk($sformatf("vec%0d_other_done", i), other, 0);
            chk($sformatf("vec%0d_rrdy_mask", i), rrdy_m, vt[i].wen ? 8'h00 : 8'h06);
            chk($sformatf("vec%0d_rwen_mask", i), rwen_m, vt[i].wen ? 8'h02 : 8'h00);
        end

        // Simultaneous requests after reset: I first, then alternating.
        rst = 1'b1;
        preload(4'd0, 32'h11111111);
        preload(4'd1, 32'h22222222);
        rst = 1'b0;
        IReq = 1; IAddr = 0; DReq = 1; DWEn = 0; DAddr = 1;
        begin
            int n_done, prev_c, n_d;
            n_done = 0; prev_c = cyc; n_d = 0;
            for (int k = 0; k < 60 && n_done < 4; k++) begin
                tick();
                if (IDone && DDone) chk("sim_both_done", 1, 0);
                if (IDone || DDone) begin
                    chk($sformatf("sim_order%0d", n_done), DDone, n_done % 2);
                    chk($sformatf("sim_gap%0d", n_done), cyc - prev_c, (n_done == 0) ? 3 : 4);
                    if (DDone) n_d++;
                    chk($sformatf("sim_idata%0d", n_done), IData, 32'h11111111);
                    chk($sformatf("sim_ddata%0d", n_done), DData, (n_d > 0) ? 32'h22222222 : 32'h0);
                    prev_c = cyc;
                    n_done++;
                end
            end
            chk("sim_count", n_done, 4);
        end
        IReq = 0; DReq = 0;
        tick();

        // Fairness: D raised during an I fetch stream is served next.
        IReq = 1; IAddr = 4;
        tick();
        DReq = 1; DWEn = 0; DAddr = 8;
        begin
            int n_done;
            n_done = 0;
            for (int k = 0; k < 40 && n_done < 2; k++) begin
                tick();
                if (IDone || DDone) begin
                    chk($sformatf("fair_who%0d", n_done), DDone, (n_done == 1) ? 1 : 0);
                    if (DDone) begin
                        chk("fair_ddata", DData, 32'hDEADBEEF);
                        DReq = 0;
                    end
                    n_done++;
                end
            end
            chk("fair_count", n_done, 2);
        end
        IReq = 0; DReq = 0;
        tick();

        // Watchdog timeout on a read that never gets RVld.
        stall = 1'b1;
        old_idata = IData;
        do_txn(0, 0, 4'd5, 32'h0, lat, err, data, rrdy_m, rwen_m, other, rrdy_done);
        chk("to_lat", lat, TIMEOUT + 1);
        chk("to_err", err, 1);
        chk("to_idata", data, old_idata);
        chk("to_rrdy_resp", rrdy_done, 0);
        stall = 1'b0;
        do_txn(1, 0, 4'd8, 32'h0, lat, err, data, rrdy_m, rwen_m, other, rrdy_done);
        chk("after_to_lat", lat, 3);
        chk("after_to_err", err, 0);
        chk("after_to_data", data, 32'hDEADBEEF);

        // Reset while a read is outstanding.
        IReq = 1; IAddr = 5;
        begin
            bit seen;
            seen = 0;
            for (int k = 0; k < 5 && !seen; k++) begin
                tick();
                if (RRdy) seen = 1;
            end
            chk("rstmid_rrdy_seen", seen, 1);
        end
        rst = 1'b1;
        tick();
        check_all_zero("rstmid");
        rst = 1'b0;
        begin
            int k_done;
            k_done = -1;
            for (int k = 1; k <= 20 && k_done < 0; k++) begin
                tick();
                if (IDone) begin
                    k_done = k;
                    chk("rstmid_idata", IData, 32'hA5A50001);
                    chk("rstmid_err", Err, 0);
                end
            end
            chk("rstmid_lat", k_done, 3);
        end
        IReq = 0;
        tick();

        // Randomized run against a transaction-level reference.
        rst = 1'b1;
        for (int a = 0; a < 16; a++) preload(4'(a), $urandom);
        rst = 1'b0;
        IReq = 0; DReq = 0;
        have_g = 0; last_d = 1; exp_idata = 0; exp_ddata = 0;
        g_c = 0; g_d = 0; g_w = 0; g_addr = 0; g_wdata = 0; g_data = 0;
        for (int c = 0; c < 3000; c++) begin
            rel    = c - g_c;
            e_rrdy = have_g && !g_w && (rel == 1 || rel == 2);
            e_rwen = have_g && g_w && rel == 1;
            e_done = have_g && rel == (g_w ? 2 : 3);
            chk("rnd_idone", IDone, e_done && !g_d);
            chk("rnd_ddone", DDone, e_done && g_d);
            chk("rnd_err", Err, 0);
            chk("rnd_rrdy", RRdy, e_rrdy);
            chk("rnd_rwen", RWEn, e_rwen);
            if (e_rrdy || e_rwen) chk("rnd_raddr", RAddr, g_addr);
            if (e_rwen) chk("rnd_rwdata", RWData, g_wdata);
            if (e_done && !g_w) begin
                if (g_d) exp_ddata = g_data;
                else exp_idata = g_data;
            end
            chk("rnd_idata", IData, exp_idata);
            chk("rnd_ddata", DData, exp_ddata);
            free = !have_g || rel >= (g_w ? 3 : 4);

            if (e_done && !g_d) IReq = 0;
            if (e_done && g_d) DReq = 0;
            if (!IReq && $urandom_range(0, 2) == 0) begin
                IReq = 1; IAddr = 32'($urandom_range(0, 15));
            end
            if (!DReq && $urandom_range(0, 2) == 0) begin
                DReq = 1; DWEn = 1'($urandom_range(0, 1));
                DAddr = 32'($urandom_range(0, 15)); DWData = $urandom;
            end

            if (free && (IReq || DReq)) begin
                if (IReq && DReq) who = !last_d;
                else who = DReq;
                g_c = c; g_d = who; g_w = who && DWEn; have_g = 1; last_d = who;
                g_addr  = who ? DAddr : IAddr;
                g_wdata = DWData;
                if (g_w) ref_mem[g_addr[3:0]] = DWData;
                else g_data = ref_mem[g_addr[3:0]];
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

- Shares the single-port word-addressed memory between two requesters inside `lanzones`:
  - the instruction-fetch port (I, read-only);
  - the load/store data port (D, read/write).
- Arbitrates round-robin and sequences the memory's RRdy/RVld read handshake and single-cycle RWEn write.
- Returns read data to the winning requester with a one-cycle done pulse.
- A watchdog aborts reads that never receive RVld.

## Interface
Parameters:
- AW, 32, address width (word address)
- DW, 32, data width
- TIMEOUT, 16, max cycles in READ waiting for RVld before abort (>=2)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- IReq  in  1  fetch request; held until IDone
- IAddr  in  AW  fetch address; stable while IReq
- IDone  out  1  one-cycle completion pulse to I
- IData  out  DW  fetch data; valid in IDone cycle, held until next I completion
- DReq  in  1  data request; held until DDone
- DWEn  in  1  1=write, 0=read; stable while DReq
- DAddr  in  AW  data address
- DWData  in  DW  write data
- DDone  out  1  one-cycle completion pulse to D
- DData  out  DW  load data; valid in DDone cycle for reads, held until next D read
- Err  out  1  pulses with IDone/DDone when the read timed out
- RRdy  out  1  read request to memory
- RVld  in  1  memory read-valid (registered in memory)
- RAddr  out  AW  memory address
- RWData  out  DW  memory write data
- RWEn  out  1  memory write enable, one cycle per write
- RData  in  DW  memory read data, valid when RVld=1

## Operation
- States: IDLE, READ, WRITE, RESP.
- IDLE:
  - If any request is pending, pick a winner and latch its address, write data and direction into internal registers.
  - Go to READ (I, or D with DWEn=0) or WRITE (D with DWEn=1).
  - RVld seen in IDLE is ignored.
- Arbitration:
  - Only one requester pending: it wins.
  - Both pending: grant the one not served last.
  - Last-served pointer updates on each grant; reset value = D, so I wins the first tie.
- READ:
  - RRdy=1 and RAddr=latched address.
  - On RVld=1: capture RData into IData or DData (winner only), clear Err, go to RESP.
  - Watchdog counter clears on entry and increments each READ cycle. If it reaches TIMEOUT-1 with RVld=0: set Err, leave the data register unchanged, go to RESP.
- WRITE: exactly one cycle with RWEn=1, RAddr/RWData = latched values, RRdy=0. Then go to RESP.
- RESP:
  - Winner's Done=1 and Err as set; RRdy=0, RWEn=0.
  - No arbitration this cycle; requesters may drop or change requests here.
  - Go to IDLE.
- Outside READ: RRdy=0. Outside WRITE: RWEn=0. RAddr/RWData hold the last latched values.
- Reset, including mid-transaction: state IDLE; the in-flight transaction is dropped with no Done, and the requester must reissue.
  - All outputs 0: IDone, DDone, Err, RRdy, RWEn, RAddr, RWData, IData, DData.
  - Watchdog 0; last-served pointer = D.

## Timing
- Read, cycle counts relative to the cycle n where IReq/DReq is seen in IDLE:
  - n+1: READ, RRdy=1.
  - n+2: RVld=1 from memory.
  - n+3: RESP, Done=1 and data valid.
  - Read latency is 3 cycles; a new grant is possible at n+4 (IDLE).
- Write: n+1 WRITE with RWEn=1; n+2 RESP with Done=1. Latency 2 cycles.
- RRdy deasserts at the edge that samples RVld=1, so the memory never sees RRdy during its RVld-clear cycle. This prevents a double read.
- Timeout: entry to READ at n+1, Done+Err at n+1+TIMEOUT.
- Done is never asserted to both requesters in the same cycle.
- Done is never asserted in IDLE.

## Test plan
- I read alone:
  - Setup: preload mem[4]=0x00000013; IReq=1, IAddr=4 at cycle n.
  - Response: RRdy high for n+1..n+2; IDone=1 and IData=0x00000013 at n+3; Err=0.
- D write then D read:
  - DReq, DWEn=1, DAddr=8, DWData=0xDEADBEEF → RWEn=1 only at n+1, DDone at n+2.
  - Reissue as a read of addr 8 → DData=0xDEADBEEF with DDone three cycles after grant.
- Simultaneous requests after reset:
  - IReq and DReq both held (I addr 0 = 0x11111111, D read addr 1 = 0x22222222).
  - I served first, then D, alternating; each Done exactly once per transaction; DData never overwritten by I reads.
- Fairness under continuous I fetch stream:
  - DReq raised mid-stream → D granted at the very next IDLE after the current I transaction.
- Timeout:
  - Memory forced RVld=0, TIMEOUT=16, I read → IDone=1 and Err=1 exactly 16 cycles after READ entry.
  - IData unchanged; RRdy low in RESP; next request completes normally.
- Reset mid-read:
  - rst=1 in the cycle RRdy=1 → next cycle all outputs 0 and state IDLE, no IDone.
  - After rst=0, a held IReq is granted and completes with correct data.
